// File: rtl/toy_datapath.sv
// toy_datapath: datapath stage under direct control of the toy-processor
// controller. Holds PC, IR, operand register D and accumulator AC, drives the
// single-port instruction/data memory and returns the one-hot opcode decode
// plus the ZERO flag the controller branches on.
//
// Ports:
//   CLK, RESET              clock (rising edge), synchronous active-high reset
//   PC_CNT, LD_PC           PC increment / load from IR address field
//   LD_IR, LD_D, LD_AC      register load strobes
//   CL, CL_AC               clear PC/IR/D, clear AC
//   ADDSUB                  ALU op: 0 = AC+D, 1 = AC-D
//   DORPC, RORW, MEM_EN     address select, read/write, memory enable
//   MEM_RDATA               asynchronous memory read data
//   MEM_ADDR/WDATA/WE/RE    memory interface outputs
//   CLR, ADD, SUB, STORE, BZ one-hot IR opcode decode
//   ZERO                    AC == 0
//   PC_Q, AC_Q, IR_Q        debug register views
module toy_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PC_CNT,
  input  logic              LD_PC,
  input  logic              LD_IR,
  input  logic              LD_D,
  input  logic              LD_AC,
  input  logic              CL,
  input  logic              CL_AC,
  input  logic              ADDSUB,
  input  logic              DORPC,
  input  logic              RORW,
  input  logic              MEM_EN,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_WE,
  output logic              MEM_RE,
  output logic              CLR,
  output logic              ADD,
  output logic              SUB,
  output logic              STORE,
  output logic              BZ,
  output logic              ZERO,
  output logic [ADDR_W-1:0] PC_Q,
  output logic [DATA_W-1:0] AC_Q,
  output logic [DATA_W-1:0] IR_Q
);

  localparam int OPC_W = DATA_W - ADDR_W;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_CLR   = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_STORE = 3'd4,
    OP_BZ    = 3'd5
  } opcode_e;

  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] d;
  logic [DATA_W-1:0] ac;
  logic [DATA_W-1:0] alu_res;
  logic [OPC_W-1:0]  opc;
  logic [ADDR_W-1:0] ir_addr;

  assign opc     = ir[DATA_W-1:ADDR_W];
  assign ir_addr = ir[ADDR_W-1:0];

  // ALU works on pre-edge register values, so LD_D together with LD_AC
  // consumes the old D.
  always_comb begin
    alu_res = ADDSUB ? (ac - d) : (ac + d);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc <= '0;
      ir <= '0;
      d  <= '0;
      ac <= '0;
    end else begin
      if (CL) begin
        pc <= '0;
        ir <= '0;
        d  <= '0;
      end else begin
        if (LD_PC) begin
          pc <= ir_addr;
        end else if (PC_CNT) begin
          pc <= pc + ADDR_W'(1);
        end
        if (LD_IR) begin
          ir <= MEM_RDATA;
        end
        if (LD_D) begin
          d <= MEM_RDATA;
        end
      end

      if (CL_AC) begin
        ac <= '0;
      end else if (LD_AC) begin
        ac <= alu_res;
      end
    end
  end

  // Opcode field is compared zero-extended, so any set bit above the 3-bit
  // code space (wide opcode fields) decodes to no line at all.
  always_comb begin
    CLR   = 1'b0;
    ADD   = 1'b0;
    SUB   = 1'b0;
    STORE = 1'b0;
    BZ    = 1'b0;
    case (opc)
      OPC_W'(OP_CLR):   CLR   = 1'b1;
      OPC_W'(OP_ADD):   ADD   = 1'b1;
      OPC_W'(OP_SUB):   SUB   = 1'b1;
      OPC_W'(OP_STORE): STORE = 1'b1;
      OPC_W'(OP_BZ):    BZ    = 1'b1;
      default: ;
    endcase
  end

  assign MEM_ADDR  = DORPC ? ir_addr : pc;
  assign MEM_WDATA = ac;
  assign MEM_RE    = MEM_EN & RORW;
  assign MEM_WE    = MEM_EN & ~RORW;
  assign ZERO      = (ac == '0);
  assign PC_Q      = pc;
  assign AC_Q      = ac;
  assign IR_Q      = ir;

endmodule

// File: tb/tb_toy_datapath.sv
module tb_toy_datapath;

  logic       CLK = 1'b0;
  logic       RESET, PC_CNT, LD_PC, LD_IR, LD_D, LD_AC, CL, CL_AC;
  logic       ADDSUB, DORPC, RORW, MEM_EN;
  logic [7:0] MEM_RDATA;
  logic [4:0] MEM_ADDR;
  logic [7:0] MEM_WDATA;
  logic       MEM_WE, MEM_RE, CLR, ADD, SUB, STORE, BZ, ZERO;
  logic [4:0] PC_Q;
  logic [7:0] AC_Q, IR_Q;

  logic [7:0] mem [32];
  int nchecks = 0;
  int nerrors = 0;
  bit cmp_en  = 1'b0;

  // Reference state, kept as plain integers
  int m_pc = 0, m_ir = 0, m_d = 0, m_ac = 0;

  always #5 CLK = ~CLK;

  assign MEM_RDATA = mem[MEM_ADDR];

  toy_datapath #(.DATA_W(8), .ADDR_W(5)) dut (
    .CLK(CLK), .RESET(RESET), .PC_CNT(PC_CNT), .LD_PC(LD_PC), .LD_IR(LD_IR),
    .LD_D(LD_D), .LD_AC(LD_AC), .CL(CL), .CL_AC(CL_AC), .ADDSUB(ADDSUB),
    .DORPC(DORPC), .RORW(RORW), .MEM_EN(MEM_EN), .MEM_RDATA(MEM_RDATA),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE), .MEM_RE(MEM_RE),
    .CLR(CLR), .ADD(ADD), .SUB(SUB), .STORE(STORE), .BZ(BZ), .ZERO(ZERO),
    .PC_Q(PC_Q), .AC_Q(AC_Q), .IR_Q(IR_Q)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decode vector {CLR,ADD,SUB,STORE,BZ} from the opcode value
  function automatic logic [4:0] exp_dec(input int ir);
    case (ir / 32)
      1: return 5'b10000;
      2: return 5'b01000;
      3: return 5'b00100;
      4: return 5'b00010;
      5: return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  // Reference update on each rising edge
  always @(posedge CLK) begin
    int addr, rd, npc, nir, nd, nac;
    addr = DORPC ? (m_ir % 32) : m_pc;
    rd   = mem[addr];
    npc = m_pc; nir = m_ir; nd = m_d; nac = m_ac;
    if (RESET) begin
      npc = 0; nir = 0; nd = 0; nac = 0;
    end else begin
      if (CL) begin
        npc = 0; nir = 0; nd = 0;
      end else begin
        if (LD_PC)       npc = m_ir % 32;
        else if (PC_CNT) npc = (m_pc + 1) % 32;
        if (LD_IR) nir = rd;
        if (LD_D)  nd  = rd;
      end
      if (CL_AC)      nac = 0;
      else if (LD_AC) nac = ADDSUB ? (m_ac - m_d + 256) % 256 : (m_ac + m_d) % 256;
    end
    m_pc = npc; m_ir = nir; m_d = nd; m_ac = nac;
  end

  // Every-cycle comparison against the reference
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("pc",    32'(PC_Q), 32'(m_pc));
      chk("ir",    32'(IR_Q), 32'(m_ir));
      chk("ac",    32'(AC_Q), 32'(m_ac));
      chk("zero",  32'(ZERO), 32'(m_ac == 0));
      chk("dec",   32'({CLR, ADD, SUB, STORE, BZ}), 32'(exp_dec(m_ir)));
      chk("addr",  32'(MEM_ADDR), 32'(DORPC ? (m_ir % 32) : m_pc));
      chk("wdata", 32'(MEM_WDATA), 32'(m_ac));
      chk("re",    32'(MEM_RE), 32'(MEM_EN && RORW));
      chk("we",    32'(MEM_WE), 32'(MEM_EN && !RORW));
    end
  end

  task automatic clr_ctl();
    RESET = 0; PC_CNT = 0; LD_PC = 0; LD_IR = 0; LD_D = 0; LD_AC = 0;
    CL = 0; CL_AC = 0; ADDSUB = 0; DORPC = 0; RORW = 0; MEM_EN = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    clr_ctl();
  endtask

  task automatic fetch_pc();
    MEM_EN = 1; RORW = 1; LD_IR = 1; DORPC = 0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0] = 8'hE5; mem[1] = 8'h21; mem[2] = 8'h62;
    mem[3] = 8'h47; mem[4] = 8'hF0; mem[5] = 8'h10;
    mem[6] = 8'hB9; mem[7] = 8'h20; mem[9] = 8'h4A;
    mem[25] = 8'h89;
    clr_ctl();
    #2;

    // Reset with competing load/count
    RESET = 1; LD_AC = 1; PC_CNT = 1;
    tick();
    cmp_en = 1'b1;
    chk("rst_pc", 32'(PC_Q), 0);
    chk("rst_ac", 32'(AC_Q), 0);
    chk("rst_ir", 32'(IR_Q), 0);
    chk("rst_zero", 32'(ZERO), 1);
    chk("rst_dec", 32'({CLR, ADD, SUB, STORE, BZ}), 0);

    // Fetch/decode at PC=3
    repeat (3) begin PC_CNT = 1; tick(); end
    MEM_EN = 1; RORW = 1; LD_IR = 1; DORPC = 0;
    #1;
    chk("fetch_addr", 32'(MEM_ADDR), 3);
    chk("fetch_re", 32'(MEM_RE), 1);
    tick();
    chk("fetch_ir", 32'(IR_Q), 32'h47);
    chk("fetch_add", 32'({CLR, ADD, SUB, STORE, BZ}), 32'b01000);
    PC_CNT = 1; tick();
    chk("pc_inc", 32'(PC_Q), 4);

    // AC = 0xF0, then add mem[7]=0x20 via IR address -> wrap to 0x10
    MEM_EN = 1; RORW = 1; LD_D = 1; tick();
    LD_AC = 1; tick();
    chk("ac_f0", 32'(AC_Q), 32'hF0);
    DORPC = 1; MEM_EN = 1; RORW = 1; LD_D = 1; tick();
    LD_AC = 1; ADDSUB = 0; tick();
    chk("add_wrap", 32'(AC_Q), 32'h10);
    chk("add_zero", 32'(ZERO), 0);

    // D = 0x10, subtract to zero
    PC_CNT = 1; tick();
    MEM_EN = 1; RORW = 1; LD_D = 1; tick();
    LD_AC = 1; ADDSUB = 1; tick();
    chk("sub_ac", 32'(AC_Q), 0);
    chk("sub_zero", 32'(ZERO), 1);

    // LD_D with LD_AC: ALU uses old D (0x10), D becomes mem[6]
    PC_CNT = 1; tick();
    LD_D = 1; LD_AC = 1; ADDSUB = 0; tick();
    chk("old_d", 32'(AC_Q), 32'h10);

    // Branch: IR = 101_11001, LD_PC beats PC_CNT
    fetch_pc();
    chk("bz_dec", 32'({CLR, ADD, SUB, STORE, BZ}), 32'b00001);
    LD_PC = 1; PC_CNT = 1; tick();
    chk("branch_pc", 32'(PC_Q), 25);

    // Store: IR = 100_01001, AC = 0x10 + 0x4A
    fetch_pc();
    chk("store_dec", 32'({CLR, ADD, SUB, STORE, BZ}), 32'b00010);
    DORPC = 1; MEM_EN = 1; RORW = 1; LD_D = 1; tick();
    LD_AC = 1; tick();
    DORPC = 1; MEM_EN = 1; RORW = 0;
    #1;
    chk("st_addr", 32'(MEM_ADDR), 9);
    chk("st_we", 32'(MEM_WE), 1);
    chk("st_re", 32'(MEM_RE), 0);
    chk("st_wdata", 32'(MEM_WDATA), 32'h5A);
    MEM_EN = 0;
    #1;
    chk("idle_we", 32'(MEM_WE), 0);
    chk("idle_re", 32'(MEM_RE), 0);
    tick();

    // PC wrap 31 -> 0
    repeat (6) begin PC_CNT = 1; tick(); end
    chk("pc_31", 32'(PC_Q), 31);
    PC_CNT = 1; tick();
    chk("pc_wrap", 32'(PC_Q), 0);

    // Clear priority
    CL_AC = 1; LD_AC = 1; tick();
    chk("cl_ac", 32'(AC_Q), 0);
    CL = 1; LD_IR = 1; MEM_EN = 1; RORW = 1; tick();
    chk("cl_ir", 32'(IR_Q), 0);

    // Opcode 111, CLR, SUB decode
    fetch_pc();
    chk("op111_ir", 32'(IR_Q), 32'hE5);
    chk("op111_dec", 32'({CLR, ADD, SUB, STORE, BZ}), 0);
    PC_CNT = 1; tick();
    fetch_pc();
    chk("clr_dec", 32'({CLR, ADD, SUB, STORE, BZ}), 32'b10000);
    PC_CNT = 1; tick();
    fetch_pc();
    chk("sub_dec", 32'({CLR, ADD, SUB, STORE, BZ}), 32'b00100);

    // Reset mid-instruction discards concurrent loads
    RESET = 1; LD_IR = 1; PC_CNT = 1; LD_AC = 1; tick();
    chk("mrst_pc", 32'(PC_Q), 0);
    chk("mrst_ir", 32'(IR_Q), 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/toy_datapath.md
Name: toy_datapath

Overview:
Datapath stage driven directly by the toy-processor controller. It holds the PC, IR, operand register D and accumulator AC, and drives the single-port instruction/data memory. It consumes every controller strobe (PC_CNT, LD_*, CL, CL_AC, ADDSUB, DORPC, RORW, MEM_EN). It returns the decoded opcode lines (CLR, ADD, SUB, STORE, BZ) and the ZERO flag that the controller branches on.

Parameters:
DATA_W, 8, word width of memory, IR, D and AC
ADDR_W, 5, memory address width; IR[ADDR_W-1:0] is the operand address, IR[DATA_W-1:ADDR_W] is the opcode (DATA_W-ADDR_W >= 3)

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  synchronous, active-high reset
PC_CNT  in  1  increment PC
LD_PC  in  1  load PC from IR address field (branch)
LD_IR  in  1  load IR from MEM_RDATA
LD_D  in  1  load D from MEM_RDATA
LD_AC  in  1  write ALU result to AC
CL  in  1  clear PC, IR, D
CL_AC  in  1  clear AC
ADDSUB  in  1  0 = AC+D, 1 = AC-D
DORPC  in  1  address select: 1 = IR address field, 0 = PC
RORW  in  1  1 = read, 0 = write
MEM_EN  in  1  memory access enable
MEM_RDATA  in  DATA_W  memory read data (asynchronous read, valid same cycle)
MEM_ADDR  out  ADDR_W  memory address
MEM_WDATA  out  DATA_W  write data (= AC)
MEM_WE  out  1  write strobe
MEM_RE  out  1  read strobe
CLR, ADD, SUB, STORE, BZ  out  1 each  one-hot decode of IR opcode
ZERO  out  1  AC == 0
PC_Q  out  ADDR_W  PC value (debug)
AC_Q  out  DATA_W  AC value (debug)
IR_Q  out  DATA_W  IR value (debug)

Behaviour:
- The clock port is CLK. The reset port is RESET: one clock, reset synchronous and active-high.
- All state changes on the rising CLK edge.
- Priority in every cycle: RESET > clear (CL / CL_AC) > load/count.
- Reset values: PC=0, IR=0, D=0, AC=0. Hence ZERO=1 and all decode lines are 0.
- PC:
  - CL -> 0.
  - Else LD_PC -> IR[ADDR_W-1:0].
  - Else PC_CNT -> PC+1, modulo 2^ADDR_W (2^ADDR_W-1 wraps to 0).
  - LD_PC and PC_CNT together: LD_PC wins.
- IR: CL -> 0; else LD_IR -> MEM_RDATA.
- D: CL -> 0; else LD_D -> MEM_RDATA.
- AC:
  - CL_AC -> 0.
  - Else LD_AC -> AC+D (ADDSUB=0) or AC-D (ADDSUB=1), truncated to DATA_W (two's-complement wrap, no carry/overflow output).
  - ALU sources are the register values before the edge. LD_D and LD_AC in the same cycle use the old D.
- ZERO is combinational from the AC register (AC == 0). It changes the cycle after the AC write, with no extra latency.
- MEM_ADDR = DORPC ? IR[ADDR_W-1:0] : PC (combinational).
- MEM_RE = MEM_EN & RORW. MEM_WE = MEM_EN & ~RORW. MEM_WDATA = AC at all times.
- Decode (combinational from IR opcode field, zero-extended compare):
  - 000 = NOP (all lines 0)
  - 001 = CLR
  - 010 = ADD
  - 011 = SUB
  - 100 = STORE
  - 101 = BZ
  - 110/111 = all lines 0
- Exactly zero or one decode line is high at any time.
- Load latency: a value captured on edge N is visible on the outputs after edge N. A fetch needs one cycle with DORPC=0, MEM_EN=1, RORW=1, LD_IR=1.
- RESET asserted mid-instruction: all registers return to reset values on that edge, and any simultaneous load/count is discarded. MEM_WE still follows the combinational MEM_EN/RORW inputs; the controller must hold MEM_EN low during reset.
- No internal FSM sequencing: sequencing belongs to the controller. The block holds no state beyond PC, IR, D, AC.

Test Plan:
- Reset: RESET=1 for 1 cycle with LD_AC=1, PC_CNT=1 -> PC=0, AC=0, IR=0, ZERO=1, all decode lines 0.
- Fetch/decode: PC=3, mem[3]=8'b010_00111, assert MEM_EN, RORW, LD_IR with DORPC=0 -> MEM_ADDR=3, MEM_RE=1, next cycle IR=0x47, ADD=1, others 0. PC_CNT one cycle -> PC=4.
- Add with wrap: AC=0xF0; DORPC=1 reads mem[7]=0x20 with LD_D; then LD_AC, ADDSUB=0 -> AC=0x10, ZERO=0.
- Subtract to zero and branch: AC=0x10, D=0x10, LD_AC with ADDSUB=1 -> AC=0, ZERO=1. IR=8'b101_11001 with LD_PC=1 and PC_CNT=1 -> PC=25, BZ=1.
- Store: AC=0x5A, IR address 9, DORPC=1, MEM_EN=1, RORW=0 -> MEM_ADDR=9, MEM_WE=1, MEM_WDATA=0x5A, MEM_RE=0. With MEM_EN=0 -> both strobes 0.
- Priority/wrap:
  - PC=31, PC_CNT=1 -> PC=0.
  - CL_AC with LD_AC -> AC=0.
  - CL with LD_IR -> IR=0.
  - Opcode 111 -> all decode lines 0.
